// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath: steps each instruction through
// fetch/decode/execute/memory/writeback, with start/halt handshake and a retired-instruction counter.
module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic             IorD,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_IR_LOAD   = 4'd2,
    S_DECODE    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_R_EXEC    = 4'd8,
    S_R_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ADDI_EX   = 4'd12,
    S_ADDI_WB   = 4'd13,
    S_HALTED    = 4'd14
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
  } ctrl_t;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic             r_halted;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  state_t           w_next;
  logic             w_retire;

  // Control word for a state; every field not named stays 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     c.mem_read = 1'b1;
      S_IR_LOAD:   begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:      begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1'b1;
      end
      S_JUMP:      begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      S_ADDI_EX:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDI_WB:   c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:      w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:     w_next = S_IR_LOAD;
      S_IR_LOAD:   w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          3'b000:         w_next = S_R_EXEC;
          3'b001:         w_next = S_ADDI_EX;
          3'b010, 3'b011: w_next = S_MEM_ADDR;
          3'b100:         w_next = S_BRANCH;
          3'b101:         w_next = S_JUMP;
          default:        w_next = S_HALTED;
        endcase
      end
      S_MEM_ADDR:  w_next = opcode[0] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = S_MEM_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EX:   w_next = S_ADDI_WB;
      S_HALTED:    w_next = start ? S_FETCH : S_HALTED;
      default:     w_next = S_IDLE;
    endcase
  end

  assign w_retire = (r_state == S_MEM_WB) || (r_state == S_MEM_WRITE) || (r_state == S_R_WB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP) || (r_state == S_ADDI_WB);

  // NOTE: controls are registered from the next state, so they change only with the state
  // register and the asynchronous reset forces every write enable low without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state  <= w_next;
      r_ctrl   <= decode(w_next);
      r_halted <= (w_next == S_HALTED);
      if ((r_state == S_DECODE) && (opcode == 3'b110))
        r_illegal <= 1'b1;
      else if ((r_state == S_HALTED) && start)
        r_illegal <= 1'b0;
      if (w_retire)
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign ALUOp       = r_ctrl.alu_op;
  assign ALUSrcA     = r_ctrl.alu_src_a;
  assign ALUSrcB     = r_ctrl.alu_src_b;
  assign PCSource    = r_ctrl.pc_source;
  assign IorD        = r_ctrl.iord;
  assign RegDst      = r_ctrl.reg_dst;
  assign MemtoReg    = r_ctrl.mem_to_reg;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign IRWrite     = r_ctrl.ir_write;
  assign PCWrite     = r_ctrl.pc_write;
  assign PCWriteCond = r_ctrl.pc_write_cond;
  assign RegWrite    = r_ctrl.reg_write;
  assign state       = r_state;
  assign halted      = r_halted;
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus random instruction streams, compared each
// cycle against an instruction-level model (state path per opcode, control table per state).
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       opcode = 3'b000;
  logic [1:0]       ALUOp, ALUSrcB, PCSource;
  logic             ALUSrcA, IorD, RegDst, MemtoReg, MemRead, MemWrite;
  logic             IRWrite, PCWrite, PCWriteCond, RegWrite;
  logic [3:0]       state;
  logic             halted, illegal_op;
  logic [CNT_W-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  int       m_prev  = 0;
  int       m_count = 0;
  logic     m_ill   = 1'b0;
  logic [2:0] cur_op = 3'b000;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .state(state), .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word per state, field order matching observed_ctrl().
  function automatic logic [16:0] exp_ctrl(input int s);
    logic [1:0] aop, bsrc, pcs;
    logic a, iord, rd, m2r, mr, mw, irw, pcw, pcwc, rw, h;
    {aop, bsrc, pcs} = '0;
    {a, iord, rd, m2r, mr, mw, irw, pcw, pcwc, rw, h} = '0;
    case (s)
      1:  mr = 1'b1;
      2:  begin irw = 1'b1; bsrc = 2'b01; pcw = 1'b1; end
      3:  bsrc = 2'b11;
      4:  begin a = 1'b1; bsrc = 2'b10; end
      5:  begin mr = 1'b1; iord = 1'b1; end
      6:  begin m2r = 1'b1; rw = 1'b1; end
      7:  begin mw = 1'b1; iord = 1'b1; end
      8:  begin a = 1'b1; aop = 2'b10; end
      9:  begin rd = 1'b1; rw = 1'b1; end
      10: begin a = 1'b1; aop = 2'b01; pcs = 2'b01; pcwc = 1'b1; end
      11: begin pcs = 2'b10; pcw = 1'b1; end
      12: begin a = 1'b1; bsrc = 2'b10; end
      13: rw = 1'b1;
      14: h = 1'b1;
      default: ;
    endcase
    return {aop, bsrc, pcs, a, iord, rd, m2r, mr, mw, irw, pcw, pcwc, rw, h};
  endfunction

  function automatic logic [16:0] observed_ctrl();
    return {ALUOp, ALUSrcB, PCSource, ALUSrcA, IorD, RegDst, MemtoReg, MemRead, MemWrite,
            IRWrite, PCWrite, PCWriteCond, RegWrite, halted};
  endfunction

  task automatic check_all(input string where);
    check($sformatf("%s.state", where), 32'(state), 32'(m_prev));
    check($sformatf("%s.ctrl", where), 32'(observed_ctrl()), 32'(exp_ctrl(m_prev)));
    check($sformatf("%s.count", where), 32'(instr_count), 32'(m_count));
    check($sformatf("%s.illegal", where), 32'(illegal_op), 32'(m_ill));
  endtask

  // One clock: inputs that the sequencer must ignore in the current state are randomised.
  task automatic step(input int exp_s, input logic st);
    start  = (m_prev == 0 || m_prev == 14) ? st : 1'($urandom_range(0, 1));
    opcode = (m_prev == 3 || m_prev == 4) ? cur_op : 3'($urandom_range(0, 7));
    @(posedge clock);
    #1;
    if (m_prev inside {6, 7, 9, 10, 11, 13}) m_count = (m_count + 1) % (1 << CNT_W);
    if (m_prev == 3 && cur_op == 3'b110) m_ill = 1'b1;
    if (m_prev == 14 && exp_s == 1) m_ill = 1'b0;
    m_prev = exp_s;
    check_all($sformatf("op%0d.s%0d", cur_op, exp_s));
  endtask

  task automatic run_op(input logic [2:0] op);
    int path[$];
    cur_op = op;
    path = '{1, 2, 3};
    case (op)
      3'd0: begin path.push_back(8);  path.push_back(9);  end
      3'd1: begin path.push_back(12); path.push_back(13); end
      3'd2: begin path.push_back(4);  path.push_back(5); path.push_back(6); end
      3'd3: begin path.push_back(4);  path.push_back(7);  end
      3'd4: path.push_back(10);
      3'd5: path.push_back(11);
      default: path.push_back(14);
    endcase
    foreach (path[i]) step(path[i], 1'b1);
  endtask

  initial begin
    // Reset state and IDLE hold without start.
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b1;
    repeat (3) step(0, 1'b0);

    // R-type, LW, BEQ, J, then an illegal opcode into HALTED.
    run_op(3'd0);
    run_op(3'd2);
    run_op(3'd4);
    run_op(3'd5);
    run_op(3'd6);
    repeat (3) step(14, 1'b0);
    check("illegal_sticky", 32'(illegal_op), 32'd1);
    run_op(3'd1);
    check("illegal_cleared", 32'(illegal_op), 32'd0);

    // Asynchronous reset in the middle of MEM_WRITE.
    cur_op = 3'd3;
    step(1, 1'b1); step(2, 1'b1); step(3, 1'b1); step(4, 1'b1); step(7, 1'b1);
    check("memwrite_before_reset", 32'(MemWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    m_prev = 0; m_count = 0; m_ill = 1'b0;
    check_all("async_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(0, 1'b0);

    // Sixteen retirements wrap the 4-bit counter; HALT then leaves it at zero.
    for (int i = 0; i < 16; i++) run_op(3'($urandom_range(0, 5)));
    run_op(3'd7);
    check("wrap_zero", 32'(instr_count), 32'd0);
    check("halt_not_illegal", 32'(illegal_op), 32'd0);
    repeat (2) step(14, 1'b0);

    // Random instruction stream including illegal/HALT and idle time in HALTED.
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)));
      if (m_prev == 14) repeat ($urandom_range(0, 3)) step(14, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
